// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-and-add multiplier controller
// and its datapath.
package mul_pkg;

   // Default operand and bus width shared by controller and datapath.
   localparam int MUL_W = 16;

   // Width of the ADD-cycle iteration counter used by the timeout feature.
   localparam int ITER_W = 16;

   // Controller states. IDLE is encoded as zero so that a reset state
   // decodes to all-zero outputs.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      ADD    = 3'd3,
      DONE   = 3'd4
   } state_t;

endpackage : mul_pkg

// File: rtl/mul_datapath.sv
// Shift-and-add style multiplier datapath: A register, down-counting B
// register and product accumulator, driven by mul_controller.
module mul_datapath
   import mul_pkg::*;
#(
   parameter int W = MUL_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] data_in,
   input  logic         lda,
   input  logic         ldb,
   input  logic         ldp,
   input  logic         clrp,
   input  logic         decb,
   output logic         eqz,
   output logic [W-1:0] product
);

   logic [W-1:0] a_reg;
   logic [W-1:0] b_reg;

   // Operand registers: A is a plain load, B loads then counts down.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
      end else begin
         if (lda) a_reg <= data_in;
         if (ldb) b_reg <= data_in;
         else if (decb) b_reg <= b_reg - W'(1);
      end
   end

   // Product accumulator: cleared on B load, adds A once per iteration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         product <= '0;
      end else if (clrp) begin
         product <= '0;
      end else if (ldp) begin
         product <= product + a_reg;
      end
   end

   // Remaining-iterations-zero flag seen by the controller.
   always_comb begin
      eqz = (b_reg == '0);
   end

endmodule : mul_datapath

// File: rtl/mul_iter_cnt.sv
// ADD-cycle iteration counter for the multiplier timeout feature.
// Cleared when the multiplier operand is loaded and advanced once per
// productive ADD cycle.
module mul_iter_cnt #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] count
);

   // Clear has priority over increment; both are mutually exclusive in use.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CW'(1);
      end
   end

endmodule : mul_iter_cnt

// File: rtl/mul_controller.sv
// Multiplier controller FSM: captures operands, sequences the datapath
// through LOAD_A / LOAD_B / ADD and pulses done on completion.
// Optional feature macro: MUL_CTRL_TIMEOUT_EN -- adds an ADD-cycle counter
// that forces completion with err=1 once MAX_ITER iterations have run.
//
// Handshake: start is a level sampled only in IDLE; a request is accepted
// on the rising edge where state is IDLE, start=1 and abort=0. done is a
// single-cycle pulse, err is meaningful only while done is high. Requests
// made while busy are dropped, not queued.
module mul_controller
   import mul_pkg::*;
#(
   parameter logic [ITER_W-1:0] MAX_ITER = 16'hFFFF,
   parameter int                W        = MUL_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         eqz,
   output logic [W-1:0] bus_out,
   output logic         lda,
   output logic         ldb,
   output logic         ldp,
   output logic         clrp,
   output logic         decb,
   output logic         busy,
   output logic         done,
   output logic         err,
   output state_t       state_dbg
);

   state_t       state_q;
   state_t       state_d;
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;
   logic         accept;
   logic         timeout;

   assign accept    = (state_q == IDLE) && start && !abort;
   assign state_dbg = state_q;

`ifdef MUL_CTRL_TIMEOUT_EN
   logic [ITER_W-1:0] iter_cnt;
   logic              err_q;

   // clrp marks the LOAD_B cycle, decb marks a productive ADD cycle.
   mul_iter_cnt #(.CW(ITER_W)) u_iter_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clrp),
      .inc   (decb),
      .count (iter_cnt)
   );

   // A finished multiply (eqz=1) is never reported as a timeout, even if it
   // used exactly MAX_ITER iterations.
   assign timeout = (state_q == ADD) && !abort && !eqz && (iter_cnt == MAX_ITER);

   // Remember that DONE was reached through the timeout path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= timeout;
      end
   end

   assign err = (state_q == DONE) && !abort && err_q;
`else
   // No counter: ADD only exits on eqz or abort. MAX_ITER has no effect here
   // and is referenced only so the default build carries no dangling parameter.
   assign timeout = (MAX_ITER == '0) && 1'b0;
   assign err     = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand capture on acceptance; later op_a/op_b changes are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
      end else if (accept) begin
         a_q <= op_a;
         b_q <= op_b;
      end
   end

   // Next-state logic; abort returns any active state to IDLE.
   always_comb begin
      state_d = state_q;
      if (state_q == IDLE) begin
         if (accept) state_d = LOAD_A;
      end else if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            LOAD_A:  state_d = LOAD_B;
            LOAD_B:  state_d = ADD;
            ADD:     state_d = (eqz || timeout) ? DONE : ADD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Output decode from state and eqz; an abort cycle drives no controls.
   always_comb begin
      bus_out = '0;
      lda     = 1'b0;
      ldb     = 1'b0;
      ldp     = 1'b0;
      clrp    = 1'b0;
      decb    = 1'b0;
      done    = 1'b0;
      busy    = (state_q != IDLE);
      if (!abort) begin
         case (state_q)
            LOAD_A: begin
               lda     = 1'b1;
               bus_out = a_q;
            end
            LOAD_B: begin
               ldb     = 1'b1;
               clrp    = 1'b1;
               bus_out = b_q;
            end
            ADD: begin
               if (!eqz && !timeout) begin
                  ldp  = 1'b1;
                  decb = 1'b1;
               end
            end
            DONE:    done = 1'b1;
            default: ;
         endcase
      end
   end

endmodule : mul_controller

// File: doc/mul_controller.md
MUL_CONTROLLER -- requirements
Module: mul_controller

Interface
REQ-001 SHALL have parameter MAX_ITER, default 16'hFFFF; ADD-cycle limit used by the timeout feature.
REQ-002 SHALL have parameter W, default 16; operand and bus width.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  request a multiply; sampled only in IDLE.
REQ-006 abort  in  1  cancel an operation in progress.
REQ-007 op_a, op_b  in  W  multiplicand and multiplier.
REQ-008 eqz  in  1  datapath counter-is-zero flag.
REQ-009 bus_out  out  W  datapath data_in drive.
REQ-010 lda, ldb, ldp, clrp, decb  out  1 each  datapath controls.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 err  out  1  timeout flag, valid with done.

Function
REQ-014 SHALL implement states IDLE, LOAD_A, LOAD_B, ADD, DONE.
REQ-015 IDLE: on start=1 and abort=0, capture op_a/op_b into internal registers; next state LOAD_A.
REQ-016 LOAD_A: lda=1, bus_out=captured A; next LOAD_B.
REQ-017 LOAD_B: ldb=1, clrp=1, bus_out=captured B; next ADD.
REQ-018 ADD with eqz=0: ldp=1, decb=1; stay in ADD.
REQ-019 ADD with eqz=1: no datapath controls asserted; next DONE.
REQ-020 DONE: done=1 for exactly one cycle; next IDLE.
REQ-021 bus_out SHALL be 0 outside LOAD_A/LOAD_B; control outputs SHALL be decoded combinationally from state and eqz.
REQ-022 Latency from the start-accept edge to the done pulse SHALL be B+4 cycles (B=0 gives 4).
REQ-023 B=0: ADD exits on its first cycle; product stays 0 via clrp.
REQ-024 A=0: B ADD cycles still execute; product 0.
REQ-025 abort=1 in any non-IDLE state: next state IDLE, no done pulse, and no datapath controls asserted in that cycle.
REQ-026 Simultaneous abort and start in IDLE: abort wins; start ignored.
REQ-027 start while busy SHALL be ignored and is not queued.
REQ-028 Captured operands SHALL be unaffected by op_a/op_b changes after acceptance.

Reset
REQ-029 rst=1 SHALL force IDLE, zero the captured operands and iteration counter, and hold all outputs at 0, independent of clk.
REQ-030 Reset mid-operation SHALL discard the operation with no done pulse; the datapath product is undefined until the next clrp.

Configuration
REQ-031 With MUL_CTRL_TIMEOUT_EN defined: an iteration counter clears on LOAD_B and increments each ADD cycle with eqz=0. Reaching MAX_ITER in ADD forces DONE with err=1 during the done cycle. err is 0 otherwise.
REQ-032 Without MUL_CTRL_TIMEOUT_EN: no counter is instantiated, err is tied to 0, and ADD exits only on eqz or abort.

Structure
REQ-033 Package mul_pkg SHALL hold the state enum typedef and the default width constant 16; the datapath SHALL reuse the width constant.
REQ-034 The iteration counter SHALL be sub-module mul_iter_cnt, instantiated only under MUL_CTRL_TIMEOUT_EN.

Verification (bench: mul_controller driving mul_datapath)
REQ-035 A=5, B=3, start pulse -> 3 ldp cycles, done 7 cycles after accept, product 15, err=0.
REQ-036 A=9, B=0 -> done 4 cycles after accept, ldp never asserted, product 0.
REQ-037 A=0, B=4 -> 4 ldp cycles, product 0; start asserted while busy is ignored and produces no second done.
REQ-038 A=7, B=10, abort on the 3rd ADD cycle -> IDLE next cycle, no done, busy=0.
REQ-039 MUL_CTRL_TIMEOUT_EN defined, MAX_ITER=4, B=10 -> exactly 4 ldp cycles, done=1 with err=1.
REQ-040 rst asserted mid-ADD, asynchronously between edges -> outputs 0 immediately, state IDLE; a following A=6, B=2 run gives product 12.
